// File: rtl/grf_wport_arbiter.sv
// Shared GRF write-port arbiter: the pipeline W stage (A) has fixed priority over a
// long-latency result path (B). Tracks outstanding B destinations and forces a bubble when B starves.
module grf_wport_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  input  logic [31:0] a_pc,
  input  logic        b_valid,
  input  logic [4:0]  b_wa,
  input  logic [31:0] b_wd,
  input  logic [31:0] b_pc,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  output logic        iss_ready,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        hold_req,
  output logic        proto_err,
  output logic        grf_we,
  output logic [4:0]  grf_wa,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [31:0] pend_q, pend_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hold_req_q;
  logic        proto_err_q;
  logic        proto_set;
  logic        a_act;
  logic        b_blk;
  logic        iss_fire;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // A write to $0 is a non-write and never blocks B.
  assign a_act = a_we & (a_wa != 5'd0);
  assign b_blk = b_valid & a_act;

  // Port grant and write-port mux.
  always_comb begin
    b_ready = 1'b0;
    grf_we  = 1'b0;
    grf_wa  = 5'd0;
    grf_wd  = 32'd0;
    grf_pc  = 32'd0;
    if (rst) begin
      b_ready = 1'b0;
    end else if (a_act) begin
      b_ready = 1'b0;
      grf_we  = 1'b1;
      grf_wa  = a_wa;
      grf_wd  = a_wd;
      grf_pc  = a_pc;
    end else if (b_valid) begin
      b_ready = 1'b1;
      grf_we  = 1'b1;
      grf_wa  = b_wa;
      grf_wd  = b_wd;
      grf_pc  = b_pc;
    end else begin
      b_ready = 1'b0;
    end
  end

  // An issue may reuse a register whose pending result is being written this very cycle.
  assign iss_ready = ~rst & (~pend_q[iss_wa] | (b_ready & (b_wa == iss_wa)));
  assign iss_fire  = iss_valid & iss_ready;
  assign set_mask  = (iss_fire && (iss_wa != 5'd0)) ? (32'd1 << iss_wa) : 32'd0;
  assign clr_mask  = (b_ready && (b_wa != 5'd0)) ? (32'd1 << b_wa) : 32'd0;
  assign pend_d    = ((pend_q & ~clr_mask) | set_mask) & ~32'd1;

  assign busy_rs   = pend_q[q_rs];
  assign busy_rt   = pend_q[q_rt];
  assign hold_req  = hold_req_q;
  assign proto_err = proto_err_q;

  // Starvation FSM: count blocked cycles, then owe B a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    proto_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (b_blk) begin
          state_d = S_WAIT;
          cnt_d   = 4'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (b_ready || !b_valid) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LIMIT) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (b_ready || !b_valid) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d   = S_HOLD;
          proto_set = a_act;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 32'd0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hold_req_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_req_q  <= (state_d == S_HOLD);
      proto_err_q <= proto_err_q | proto_set;
    end
  end

endmodule

// File: doc/grf_wport_arbiter.md
# grf_wport_arbiter

Arbiter and scoreboard for the single write port of the general register file. Two writers share the port: the in-order pipeline W stage (port A, non-stallable, fixed priority) and a long-latency unit such as the multiply/divide result path (port B, valid/ready). The block tracks which registers have B results outstanding so decode can stall on them. It also forces a pipeline bubble when B has been starved for too long. It sits between the W stage / long-latency unit and the register file write inputs (write enable, write address, write data, PC).

## Interface
- STARVE_LIMIT, default 4: consecutive blocked cycles of a B request before the block requests a pipeline bubble; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- a_we / a_wa / a_wd / a_pc  in  1/5/32/32  pipeline write request, address, data and PC.
- b_valid / b_wa / b_wd / b_pc  in  1/5/32/32  long-latency write request, address, data and PC.
- b_ready  out  1  B write accepted this cycle.
- iss_valid / iss_wa  in  1/5  long-latency op issued, with its destination register.
- iss_ready  out  1  issue accepted.
- q_rs / q_rt  in  5/5  decode-stage source registers.
- busy_rs / busy_rt  out  1/1  source register has a B result outstanding.
- hold_req  out  1  pipeline must present a_we=0 on the next cycle.
- proto_err  out  1  sticky; pipeline wrote while a bubble was owed.
- grf_we / grf_wa / grf_wd / grf_pc  out  1/5/32/32  to the register file write port.

## Operation
- A is active when a_we=1 and a_wa!=0. B is blocked when b_valid=1 and A is active.
- Grant: b_ready = b_valid & ~A active. The grf_* outputs carry A when A is active, B when b_ready=1, and otherwise zeros.
- A write to $0 is treated as no write. It does not block B, and grf_we=0 unless B is granted.
- Scoreboard: `pend[31:0]` is a register; bit 0 is always 0.
  - Issue acceptance: iss_ready = ~pend[iss_wa] | (b_ready & b_wa==iss_wa). A fire is iss_valid & iss_ready.
  - On a fire with iss_wa!=0, set pend[iss_wa].
  - On b_ready with b_wa!=0, clear pend[b_wa].
  - If set and clear target the same register in the same cycle, set wins, so the bit stays 1.
- busy_rs = pend[q_rs]; busy_rt = pend[q_rt]. Both are combinational from registered state. A same-cycle B grant does not bypass busy; the write lands through the register file's own forwarding.
- Starvation FSM, states IDLE, WAIT, HOLD, with a 4-bit counter `cnt`:
  - IDLE: if B is blocked, go to WAIT with cnt=1. Otherwise stay, cnt=0.
  - WAIT: if b_ready, or b_valid drops, go to IDLE with cnt=0. If still blocked and cnt==STARVE_LIMIT, go to HOLD. Otherwise cnt+1.
  - HOLD: hold_req=1. If b_ready, go to IDLE with cnt=0. If b_valid drops, go to IDLE. If A is active, A still wins, proto_err is set, and the state stays HOLD.
- hold_req is a registered output: it is 1 exactly while the state is HOLD.

## Timing
- Reset values:
  - Registered state: pend=0, state=IDLE, cnt=0, hold_req=0, proto_err=0.
  - Combinational outputs follow their inputs from the first cycle after reset: b_ready, grf_*, iss_ready, busy_*.
  - While rst=1, b_ready=0 and iss_ready=0.
- Reset arriving mid-operation clears pend and returns the FSM to IDLE within that same edge. It does not emit a write.
- Grant latency:
  - B unblocked: combinational, 0 cycles.
  - B blocked continuously: hold_req rises STARVE_LIMIT+1 cycles after b_valid first rises. A compliant pipeline lets B through on the next cycle, so the worst case is STARVE_LIMIT+2 cycles.
- Handshake rules:
  - B must hold b_wa, b_wd and b_pc stable while b_valid=1 and b_ready=0.
  - A B write completes on the rising edge where b_valid & b_ready.
- The issue and grant of the same register in one cycle is the back-to-back reuse case; the register remains pending for the new op.

## Test plan
- Reset, then B writes while a_we=0: b_valid=1, b_wa=5, b_wd=0x1234 -> b_ready=1 in the same cycle; grf_we=1, grf_wa=5, grf_wd=0x1234.
- Priority, STARVE_LIMIT=4: A writes reg 3 every cycle while b_valid=1 to reg 7 -> b_ready=0 throughout. hold_req rises on the 6th cycle after b_valid rises. With a_we=0 the next cycle, b_ready=1, grf_wa=7, and hold_req=0 on the following cycle.
- Protocol error: keep a_we=1 with a_wa=3 while hold_req=1 -> A is written, proto_err=1 sticks, hold_req stays 1 until B is granted.
- Scoreboard: issue reg 9, then q_rs=9 -> busy_rs=1. B writes reg 9 -> busy_rs=0 the next cycle. A second issue to reg 9 while pending -> iss_ready=0.
- Same-cycle reuse: issue reg 9 in the same cycle B writes reg 9 -> iss_ready=1 and pend[9]=1 afterwards. Issue to reg 0 -> iss_ready=1 and pend unchanged.
- Reset mid-HOLD with pend=0x00000200 -> next cycle hold_req=0, pend=0, state=IDLE, proto_err=0.
